// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_pkg
// Description : Shared types and helpers for the narrow-to-wide stream packer.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    // Packer output-register occupancy: collecting lanes or presenting a word.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    // Width of the lane counter for a given packing ratio.
    function automatic int lane_cnt_w(input int ratio);
        return $clog2(ratio);
    endfunction

endpackage : stream_pkg
`default_nettype wire

// File: rtl/stream_width_packer.sv
`default_nettype none
// ============================================================================
// Module      : stream_width_packer
// Description : Packs RATIO consecutive narrow valid/ready beats into one wide
//               word with per-lane keep bits; in_last closes a word early.
//               The packing register doubles as the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_width_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [DATA_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int                c_CW        = lane_cnt_w(RATIO);
    localparam logic [c_CW-1:0]   c_LAST_LANE = c_CW'(RATIO - 1);
    localparam logic [c_CW-1:0]   c_ONE       = c_CW'(1);

    // Reject ratios the packing scheme cannot support.
    generate
        if (RATIO < 2 || RATIO > 16) begin : g_ratio_check
            $error("stream_width_packer: RATIO must be in 2..16");
        end
    endgenerate

    pack_state_t                  r_state, w_state_nxt;
    logic [c_CW-1:0]              r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH*RATIO-1:0]  r_data, w_data_nxt;
    logic [RATIO-1:0]             r_keep, w_keep_nxt;
    logic                         r_last, w_last_nxt;
    logic                         w_accept;
    logic                         w_xfer;

    // A held word can be replaced in the same cycle it is taken, so input
    // readiness follows out_ready combinationally while holding.
    assign in_ready  = (r_state == FILL) || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = (r_state == HOLD) && out_ready;

    assign out_data  = r_data;
    assign out_keep  = r_keep;
    assign out_last  = r_last;
    assign out_valid = (r_state == HOLD);

    // Next-state, lane counter and packing-register contents.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_keep_nxt  = r_keep;
        w_last_nxt  = r_last;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_data_nxt[r_cnt*DATA_WIDTH +: DATA_WIDTH] = in_data;
                    w_keep_nxt[r_cnt]                          = 1'b1;
                    if (r_cnt == c_LAST_LANE || in_last) begin
                        w_state_nxt = HOLD;
                        w_last_nxt  = in_last;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_ONE;
                    end
                end
            end
            HOLD: begin
                if (w_xfer) begin
                    w_data_nxt = '0;
                    w_keep_nxt = '0;
                    w_last_nxt = 1'b0;
                    if (w_accept) begin
                        // Fresh word starts in lane 0; RATIO>=2 means only
                        // in_last can complete it immediately.
                        w_data_nxt[DATA_WIDTH-1:0] = in_data;
                        w_keep_nxt[0]              = 1'b1;
                        w_last_nxt                 = in_last;
                        if (in_last) begin
                            w_state_nxt = HOLD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = FILL;
                            w_cnt_nxt   = c_ONE;
                        end
                    end else begin
                        w_state_nxt = FILL;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = FILL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, lane counter and packed word; reset discards any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_keep  <= w_keep_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule : stream_width_packer
`default_nettype wire

// File: tb/tb_stream_width_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_width_packer
// Description : Self-checking bench for stream_width_packer: directed steps
//               plus random traffic against a lane-grouping reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_width_packer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic              clk;
    logic              reset;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DW*R-1:0]   out_data;
    logic [R-1:0]      out_keep;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    int errors = 0;
    int checks = 0;

    stream_width_packer #(
        .DATA_WIDTH (DW),
        .RATIO      (R)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: group accepted beats into words -----
    typedef struct {
        logic [DW*R-1:0] data;
        logic [R-1:0]    keep;
        logic            last;
    } word_t;

    logic [DW-1:0] m_lanes[$];
    word_t         exp_q[$];
    int            words_seen = 0;
    int            stalls     = 0;
    bit            stream_phase = 1'b0;

    // Sampled mid-cycle, when both inputs and DUT outputs are settled.
    always @(negedge clk) begin
        if (reset) begin
            m_lanes.delete();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                words_seen++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_word observed=%0h expected=none", out_data);
                end
                if (exp_q.size() != 0) begin
                    word_t e;
                    e = exp_q.pop_front();
                    checks++;
                    assert ({out_data, out_keep, out_last} === {e.data, e.keep, e.last}) else begin
                        errors++;
                        $error("FAIL model_word observed=%0h/%0b/%0b expected=%0h/%0b/%0b",
                               out_data, out_keep, out_last, e.data, e.keep, e.last);
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_lanes.push_back(in_data);
                if (m_lanes.size() == R || in_last) begin
                    word_t w;
                    w.data = '0;
                    w.keep = '0;
                    w.last = in_last;
                    for (int i = 0; i < m_lanes.size(); i++) begin
                        w.data[i*DW +: DW] = m_lanes[i];
                        w.keep[i]          = 1'b1;
                    end
                    exp_q.push_back(w);
                    m_lanes.delete();
                end
            end
            if (stream_phase && in_valid && !in_ready) stalls++;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // ---------------- directed sequence ------------------------------------
    initial begin
        int w0;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_keep",  64'(out_keep),  64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;
        step();

        // Full word
        out_ready = 1'b1;
        beat(8'h11, 1'b0);
        check("fill_valid_lo", 64'(out_valid), 64'd0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        beat(8'h44, 1'b0);
        idle();
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_data",  64'(out_data),  64'h44332211);
        check("full_keep",  64'(out_keep),  64'hF);
        check("full_last",  64'(out_last),  64'd0);
        step();
        check("full_drain_valid", 64'(out_valid), 64'd0);
        check("full_drain_data",  64'(out_data),  64'd0);

        // Partial word
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        idle();
        check("part_data", 64'(out_data), 64'h0000BBAA);
        check("part_keep", 64'(out_keep), 64'h3);
        check("part_last", 64'(out_last), 64'd1);
        step();

        // Backpressure
        out_ready = 1'b0;
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h03, 1'b0);
        beat(8'h04, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 64'(in_ready),  64'd0);
            check("bp_valid",    64'(out_valid), 64'd1);
            check("bp_data",     64'(out_data),  64'h04030201);
            check("bp_keep",     64'(out_keep),  64'hF);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        idle();
        out_ready = 1'b0;
        check("bp_new_valid", 64'(out_valid), 64'd0);
        check("bp_new_data",  64'(out_data),  64'h55);
        check("bp_new_keep",  64'(out_keep),  64'h1);

        // Single-beat packet during transfer
        beat(8'h66, 1'b1);
        check("pre_single_data", 64'(out_data), 64'h6655);
        out_ready = 1'b1;
        beat(8'h77, 1'b1);
        idle();
        check("single_valid", 64'(out_valid), 64'd1);
        check("single_data",  64'(out_data),  64'h77);
        check("single_keep",  64'(out_keep),  64'h1);
        check("single_last",  64'(out_last),  64'd1);
        step();
        check("single_drain", 64'(out_valid), 64'd0);

        // Streaming
        w0 = words_seen;
        stream_phase = 1'b1;
        for (int i = 0; i < 64; i++) beat(8'($urandom), 1'b0);
        stream_phase = 1'b0;
        idle();
        step();
        step();
        check("stream_words",  64'(words_seen - w0), 64'd16);
        check("stream_stalls", 64'(stalls),          64'd0);

        // Random traffic with random last/valid/backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_last   = 1'($urandom_range(0, 5) == 0);
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) beat(8'($urandom), i == 3);
        idle();
        step();
        check("random_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-word
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        idle();
        #2;
        reset = 1'b1;
        #1;
        check("amid_rst_data",  64'(out_data),  64'd0);
        check("amid_rst_keep",  64'(out_keep),  64'd0);
        check("amid_rst_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'h99;
        step();
        idle();
        step();
        reset = 1'b0;
        step();
        beat(8'hD1, 1'b0);
        beat(8'hD2, 1'b0);
        beat(8'hD3, 1'b0);
        beat(8'hD4, 1'b0);
        idle();
        check("post_rst_data", 64'(out_data), 64'hD4D3D2D1);
        check("post_rst_keep", 64'(out_keep), 64'hF);
        step();
        step();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_stream_width_packer
`default_nettype wire

// File: doc/stream_width_packer.md
# stream_width_packer

Downstream neighbour of the single-stage pipeline register: consumes its narrow valid/ready beat stream and packs RATIO consecutive beats into one wide word for the wide datapath that follows. It supports early termination of a packet via `in_last`, emitting a partial word with per-lane keep bits. Full input throughput is maintained: one beat per cycle while the wide side keeps `out_ready` high.

## Interface
- `DATA_WIDTH`, 8, width of one input beat (lane).
- `RATIO`, 4, beats per output word; legal range 2..16.
- `clk`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_data`  input  DATA_WIDTH  beat data.
- `in_valid`  input  1  beat present.
- `in_last`  input  1  beat is the final beat of its packet; qualified by `in_valid`.
- `in_ready`  output  1  packer can take a beat this cycle.
- `out_data`  output  DATA_WIDTH*RATIO  packed word; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- `out_keep`  output  RATIO  bit k set when lane k holds a real beat.
- `out_last`  output  1  word closes a packet.
- `out_valid`  output  1  word present.
- `out_ready`  input  1  consumer takes the word this cycle.

## Operation
- The packing register is the output register. Two states:
  - FILL: collecting, `out_valid`=0.
  - HOLD: word presented, `out_valid`=1.
- Lane counter `cnt`: $clog2(RATIO) bits, 0..RATIO-1.
- Input accept when `in_valid && in_ready`. Output transfer when `out_valid && out_ready`.
- `in_ready` = (state==FILL) || `out_ready`. This is combinational, with no registered path from `in_valid`.
- Accept in FILL:
  - Write `in_data` to lane `cnt` and set `out_keep[cnt]`.
  - If `cnt`==RATIO-1 or `in_last`: go to HOLD, set `out_last`=`in_last`, set `cnt`=0.
  - Otherwise `cnt`++.
- Transfer in HOLD with no accept:
  - Go to FILL.
  - Clear `out_data`, `out_keep` and `out_last` to 0.
- Transfer in HOLD with a simultaneous accept:
  - Start a fresh word. All lanes are cleared, then the beat is written to lane 0 with `out_keep`=1'b1 in lane 0.
  - If `in_last` is set (or RATIO would be reached, which is impossible since RATIO>=2), stay in HOLD with the single-lane word and `out_last`=`in_last`.
  - Otherwise go to FILL with `cnt`=1.
- Lanes not written in the current word read as zero. `out_keep` is always contiguous from bit 0.
- `in_last` with `in_valid`=0 is ignored.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert is supplied externally):
  - state=FILL, `cnt`=0, `out_valid`=0.
  - `out_data`=0, `out_keep`=0, `out_last`=0.
  - `in_ready` therefore reads 1.
- Latency: `out_valid` rises on the edge that accepts the completing beat (last lane or `in_last`), i.e. 1 cycle after that beat is presented.
- While `out_valid`=1 and `out_ready`=0, `out_data`/`out_keep`/`out_last` are held stable and `in_ready`=0.
- Throughput: with continuous `in_valid` and `out_ready`, one output word per RATIO cycles and zero input stalls.
- Reset mid-word: a partial word is discarded with no output. Any beat presented in the reset cycle is dropped.
- `out_ready` asserted in FILL has no effect.

## Structure
- Shared package `stream_pkg`:
  - `typedef enum logic {FILL, HOLD} pack_state_t`.
  - Function `lane_cnt_w(RATIO)` returning $clog2(RATIO).
- No sub-module. Single always_ff for state, `cnt` and data, plus one continuous assign for `in_ready`. Parameter check: elaboration-time error if RATIO<2.

## Test plan
- Full word:
  - Stimulus: reset, then beats 0x11,0x22,0x33,0x44 on consecutive cycles, `out_ready`=1.
  - Response: next cycle `out_valid`=1, `out_data`=0x44332211, `out_keep`=4'b1111, `out_last`=0.
- Partial word:
  - Stimulus: beats 0xAA, then 0xBB with `in_last`=1.
  - Response: `out_data`=0x0000BBAA, `out_keep`=4'b0011, `out_last`=1.
- Backpressure:
  - Stimulus: complete a word with `out_ready`=0 for 5 cycles.
  - Response: `in_ready`=0 and the output holds stable all 5 cycles. On `out_ready`=1 with 0x55 presented, the word transfers and the new word has lane0=0x55 with `out_keep`=4'b0001 in FILL.
- Single-beat packet during transfer:
  - Stimulus: in HOLD, assert `out_ready` together with 0x77 and `in_last`=1.
  - Response: the next word is 0x00000077, `out_keep`=4'b0001, `out_last`=1, `out_valid` stays 1.
- Streaming:
  - Stimulus: 64 random beats with `in_valid`=1 and `out_ready`=1.
  - Response: 16 words in order, `in_ready` never 0, each word matches the model.
- Reset mid-word:
  - Stimulus: two beats, assert `reset` asynchronously, deassert, then send 4 new beats.
  - Response: outputs are 0 immediately on reset. The first word contains only the new 4 beats.
